// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - opcode values and fetch sequencer state encoding
package isa_pkg;

  localparam logic [3:0] ISA_NOP = 4'h0;
  localparam logic [3:0] ISA_JMP = 4'hE;
  localparam logic [3:0] ISA_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    ISSUE  = 2'd2,
    HALT   = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_register.sv
// rtl/instruction_register.sv - instruction word holding register with load enable
module instruction_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] ir_d;

  always_comb begin
    ir_d = ir_q;
    if (load) ir_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) ir_q <= '0;
    else     ir_q <= ir_d;
  end

  assign q = ir_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Moore fetch/decode/issue sequencer between PC and execute stage
module fetch_unit
  import isa_pkg::*;
#(
  parameter int                     DATA_WIDTH   = 8,
  parameter int                     ADDR_WIDTH   = 4,
  parameter int                     OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] JMP_OPCODE  = ISA_JMP,
  parameter logic [OPCODE_WIDTH-1:0] HLT_OPCODE  = ISA_HLT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   pc_in,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic [ADDR_WIDTH-1:0]   pc_load_value,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  input  logic                    mem_ready,
  output logic                    instr_valid,
  input  logic                    exec_ready,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [ADDR_WIDTH-1:0]   operand,
  output logic                    halted
);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [DATA_WIDTH-1:0]   ir;
  logic                    ir_load;
  logic [OPCODE_WIDTH-1:0] ir_opcode;
  logic [ADDR_WIDTH-1:0]   ir_operand;

  assign ir_load    = (state_q == FETCH) && mem_ready;
  assign ir_opcode  = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign ir_operand = ir[ADDR_WIDTH-1:0];

  instruction_register #(
    .WIDTH (DATA_WIDTH)
  ) u_ir (
    .clk  (clk),
    .rst  (rst),
    .load (ir_load),
    .d    (mem_data),
    .q    (ir)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = '0;
    mem_addr      = '0;
    mem_rd        = 1'b0;
    instr_valid   = 1'b0;
    opcode        = ir_opcode;
    operand       = ir_operand;
    halted        = 1'b0;
    case (state_q)
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc_in;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        if (ir_opcode == JMP_OPCODE) begin
          pc_load       = 1'b1;
          pc_load_value = ir_operand;
          state_d       = FETCH;
        end else if (ir_opcode == HLT_OPCODE) begin
          state_d = HALT;
        end else begin
          pc_inc  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (exec_ready) state_d = FETCH;
      end
      default: begin
        // Halted: only the halted flag is visible until reset.
        halted  = 1'b1;
        opcode  = ISA_NOP;
        operand = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with PC and memory models
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       pc_rst;
  logic [3:0] pc;
  logic       pc_inc;
  logic       pc_load;
  logic [3:0] pc_load_value;
  logic [3:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic       instr_valid;
  logic       exec_ready;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       halted;

  logic [7:0] mem [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc),
    .pc_inc        (pc_inc),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .instr_valid   (instr_valid),
    .exec_ready    (exec_ready),
    .opcode        (opcode),
    .operand       (operand),
    .halted        (halted)
  );

  assign mem_data = mem[mem_addr];

  always_ff @(posedge clk) begin
    if (pc_rst)       pc <= 4'd0;
    else if (pc_load) pc <= pc_load_value;
    else if (pc_inc)  pc <= pc + 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h12;
    mem[1] = 8'h34;
    mem[2] = 8'hE7;
    mem[3] = 8'hF0;
    mem[7] = 8'h56;
    mem[8] = 8'hE3;

    rst = 1'b1; pc_rst = 1'b1; mem_ready = 1'b1; exec_ready = 1'b1;
    @(negedge clk);
    tick(); tick(); tick();
    rst = 1'b0; pc_rst = 1'b0;

    // reset state
    check("rst_mem_rd", mem_rd, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_pc_inc", pc_inc, 0);
    check("rst_pc_load", pc_load, 0);
    check("rst_halted", halted, 0);
    check("rst_opcode", opcode, 0);
    check("rst_operand", operand, 0);

    // straight line: 0x12 then 0x34
    tick();
    check("i0_dec_pc_inc", pc_inc, 1);
    check("i0_dec_opcode", opcode, 1);
    check("i0_dec_operand", operand, 2);
    check("i0_dec_valid", instr_valid, 0);
    check("i0_dec_mem_rd", mem_rd, 0);
    tick();
    check("i0_iss_valid", instr_valid, 1);
    check("i0_iss_opcode", opcode, 1);
    check("i0_iss_operand", operand, 2);
    check("i0_iss_pc_inc", pc_inc, 0);
    tick();
    check("i1_fetch_mem_rd", mem_rd, 1);
    check("i1_fetch_addr", mem_addr, 1);
    check("i1_fetch_pc_inc", pc_inc, 0);
    tick();
    check("i1_dec_pc_inc", pc_inc, 1);
    check("i1_dec_opcode", opcode, 3);
    check("i1_dec_operand", operand, 4);
    tick();
    check("i1_iss_valid", instr_valid, 1);
    tick();
    check("i2_fetch_addr", mem_addr, 2);

    // jump to 7
    tick();
    check("jmp_pc_load", pc_load, 1);
    check("jmp_load_value", pc_load_value, 7);
    check("jmp_pc_inc", pc_inc, 0);
    check("jmp_valid", instr_valid, 0);
    tick();
    check("jmp_fetch_addr", mem_addr, 7);
    check("jmp_fetch_pc_load", pc_load, 0);
    check("jmp_fetch_mem_rd", mem_rd, 1);

    // memory backpressure: mem_rd held 5 cycles
    mem_ready = 1'b0; exec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_mem_rd", mem_rd, 1);
      check("bp_mem_addr", mem_addr, 7);
      tick();
    end
    check("bp_mem_rd_last", mem_rd, 1);
    mem_ready = 1'b1;
    tick();
    check("bp_dec_pc_inc", pc_inc, 1);
    check("bp_dec_opcode", opcode, 5);
    // execute backpressure: instr_valid held 4 cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_iss_valid", instr_valid, 1);
      check("bp_iss_opcode", opcode, 5);
      check("bp_iss_operand", operand, 6);
      check("bp_iss_pc_inc", pc_inc, 0);
      check("bp_iss_mem_rd", mem_rd, 0);
    end
    exec_ready = 1'b1;
    tick();
    check("bp_next_fetch_valid", instr_valid, 0);
    check("bp_next_fetch_addr", mem_addr, 8);

    // jump to 3, then halt
    tick();
    check("jmp3_pc_load", pc_load, 1);
    check("jmp3_value", pc_load_value, 3);
    tick();
    check("hlt_fetch_addr", mem_addr, 3);
    tick();
    check("hlt_dec_pc_inc", pc_inc, 0);
    check("hlt_dec_pc_load", pc_load, 0);
    check("hlt_dec_halted", halted, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      exec_ready = i[0];
      mem_ready  = i[1];
      check("halt_halted", halted, 1);
      check("halt_mem_rd", mem_rd, 0);
      check("halt_pc_inc", pc_inc, 0);
      check("halt_pc_load", pc_load, 0);
      check("halt_valid", instr_valid, 0);
      check("halt_opcode", opcode, 0);
    end
    check("halt_pc_frozen", pc, 3);

    rst = 1'b1; pc_rst = 1'b1; mem_ready = 1'b1; exec_ready = 1'b1;
    tick();
    rst = 1'b0; pc_rst = 1'b0;
    check("post_halt_halted", halted, 0);
    check("post_halt_mem_rd", mem_rd, 1);
    check("post_halt_addr", mem_addr, 0);

    // reset during a stalled fetch
    tick();
    check("r6_dec_opcode", opcode, 1);
    tick();
    tick();
    check("r6_fetch_addr", mem_addr, 1);
    mem_ready = 1'b0;
    tick();
    check("r6_stall_opcode", opcode, 1);
    rst = 1'b1;
    tick();
    check("r6_rst_pc_inc", pc_inc, 0);
    check("r6_rst_opcode", opcode, 0);
    check("r6_rst_mem_rd", mem_rd, 1);
    check("r6_rst_addr", mem_addr, 1);
    rst = 1'b0;
    tick();
    check("r6_still_fetch", mem_rd, 1);
    check("r6_no_ir_load", opcode, 0);
    mem_ready = 1'b1;
    tick();
    check("r6_refetch_opcode", opcode, 3);
    check("r6_refetch_pc_inc", pc_inc, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
